// File: rtl/axi_point_memory_responder_if.sv
// AXI4 subordinate-side bus bundle for the point memory responder.
// The slave modport is the responder's view; master is the requester's view.
interface axi_point_memory_responder_if #(
   parameter int memory_addr_width = 32,
   parameter int memory_data_width = 32
);
   // read address channel
   logic [memory_addr_width-1:0]     memory_araddr;
   logic                             memory_arvalid;
   logic                             memory_arready;
   logic [31:0]                      memory_arid;
   logic [7:0]                       memory_arlen;
   logic [2:0]                       memory_arsize;
   // read data channel
   logic [memory_data_width-1:0]     memory_rdata;
   logic [1:0]                       memory_rresp;
   logic [31:0]                      memory_rid;
   logic                             memory_rlast;
   logic                             memory_rvalid;
   logic                             memory_rready;
   // write address channel
   logic [memory_addr_width-1:0]     memory_awaddr;
   logic [31:0]                      memory_awid;
   logic                             memory_awvalid;
   logic                             memory_awready;
   // write data channel
   logic [memory_data_width-1:0]     memory_wdata;
   logic [memory_data_width/8-1:0]   memory_wstrb;
   logic                             memory_wlast;
   logic                             memory_wvalid;
   logic                             memory_wready;
   // write response channel
   logic [1:0]                       memory_bresp;
   logic [31:0]                      memory_bid;
   logic                             memory_bvalid;
   logic                             memory_bready;

   modport slave (
      input  memory_araddr, memory_arvalid, memory_arid, memory_arlen, memory_arsize,
      output memory_arready,
      output memory_rdata, memory_rresp, memory_rid, memory_rlast, memory_rvalid,
      input  memory_rready,
      input  memory_awaddr, memory_awid, memory_awvalid,
      output memory_awready,
      input  memory_wdata, memory_wstrb, memory_wlast, memory_wvalid,
      output memory_wready,
      output memory_bresp, memory_bid, memory_bvalid,
      input  memory_bready
   );

   modport master (
      output memory_araddr, memory_arvalid, memory_arid, memory_arlen, memory_arsize,
      input  memory_arready,
      input  memory_rdata, memory_rresp, memory_rid, memory_rlast, memory_rvalid,
      output memory_rready,
      output memory_awaddr, memory_awid, memory_awvalid,
      input  memory_awready,
      output memory_wdata, memory_wstrb, memory_wlast, memory_wvalid,
      input  memory_wready,
      input  memory_bresp, memory_bid, memory_bvalid,
      output memory_bready
   );
endinterface

// File: rtl/axi_point_memory_responder.sv
// AXI4 single-beat responder backed by on-chip RAM.
// Reads: sampled at AR handshake, delayed through a fixed-latency shift pipeline,
// queued in an in-order FIFO and returned with the echoed ID.
// Writes: AW and W each park in a one-entry holding register; when both are
// present the write commits (byte strobed) and a single B response is raised.
module axi_point_memory_responder #(
   parameter int                            memory_addr_width = 32,
   parameter int                            memory_data_width = 32,
   parameter int                            depth_log2        = 10,
   parameter logic [memory_addr_width-1:0]  memory_addr_base  = 32'h0000_0000,
   parameter int                            read_latency      = 2,
   parameter int                            max_outstanding   = 4
) (
   input  logic                             clock,
   input  logic                             reset,
   axi_point_memory_responder_if.slave      bus
);

   localparam int BYTES  = memory_data_width / 8;
   localparam int SHIFT  = $clog2(BYTES);
   localparam int DEPTH  = 2 ** depth_log2;
   localparam int AWP    = memory_addr_width + 1;
   localparam int PW     = (max_outstanding > 1) ? $clog2(max_outstanding) : 1;
   localparam int CW     = $clog2(max_outstanding + 1);

   localparam logic [CW-1:0]  MAXO      = CW'(max_outstanding);
   localparam logic [CW-1:0]  ONE_C     = CW'(1);
   localparam logic [PW-1:0]  PTR_LAST  = PW'(max_outstanding - 1);
   localparam logic [PW-1:0]  ONE_P     = PW'(1);
   localparam logic [2:0]     AR_SIZE   = 3'(SHIFT);
   localparam logic [AWP-1:0] LOW_MASK  = AWP'(BYTES - 1);
   localparam logic [1:0]     RESP_OKAY = 2'b00;
   localparam logic [1:0]     RESP_SLV  = 2'b10;

   typedef struct packed {
      logic                          vld;
      logic                          err;
      logic [31:0]                   id;
      logic [memory_data_width-1:0]  data;
   } rd_ent_t;

   // Address decode: error when below base, not word aligned, or past the RAM end.
   function automatic logic addr_err(input logic [memory_addr_width-1:0] addr);
      logic [AWP-1:0] off;
      logic [AWP-1:0] idx;
      off = {1'b0, addr} - {1'b0, memory_addr_base};
      idx = off >> SHIFT;
      return off[AWP-1] || ((off & LOW_MASK) != '0) || ((idx >> depth_log2) != '0);
   endfunction

   // Word index of an address (only meaningful when addr_err is 0).
   function automatic logic [depth_log2-1:0] addr_index(input logic [memory_addr_width-1:0] addr);
      logic [memory_addr_width-1:0] off;
      off = addr - memory_addr_base;
      return depth_log2'(off >> SHIFT);
   endfunction

   // Byte-strobed merge of new write data into an existing word.
   function automatic logic [memory_data_width-1:0] strb_merge(
      input logic [memory_data_width-1:0] old_word,
      input logic [memory_data_width-1:0] new_word,
      input logic [BYTES-1:0]             strb
   );
      logic [memory_data_width-1:0] res;
      res = old_word;
      for (int b = 0; b < BYTES; b++) begin
         if (strb[b]) begin
            res[b*8 +: 8] = new_word[b*8 +: 8];
         end
      end
      return res;
   endfunction

   // ---------------------------------------------------------------- storage
   logic [memory_data_width-1:0] r_mem [0:DEPTH-1];

   // ---------------------------------------------------------------- read side
   logic                 r_arready;
   logic [CW-1:0]        r_outst;
   logic [CW-1:0]        w_outst_next;
   logic                 w_ar_hs;
   logic                 w_r_hs;
   logic                 w_ar_err;
   logic [depth_log2-1:0] w_ar_idx;
   rd_ent_t              w_ar_ent;
   rd_ent_t              w_tap;
   rd_ent_t              w_head;

   rd_ent_t              r_fifo [0:max_outstanding-1];
   logic [PW-1:0]        r_wptr;
   logic [PW-1:0]        r_rptr;
   logic [CW-1:0]        r_fcnt;
   logic [CW-1:0]        w_fcnt_next;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_rvalid;

   assign w_ar_hs  = bus.memory_arvalid && r_arready;
   assign w_rvalid = (r_fcnt != '0);
   assign w_r_hs   = w_rvalid && bus.memory_rready;
   assign w_ar_err = addr_err(bus.memory_araddr) || (bus.memory_arlen != 8'd0) ||
                     (bus.memory_arsize != AR_SIZE);
   assign w_ar_idx = addr_index(bus.memory_araddr);

   // Build the read entry; RAM is sampled here so a same-edge write is not seen.
   always_comb begin
      w_ar_ent      = '0;
      w_ar_ent.vld  = w_ar_hs;
      w_ar_ent.err  = w_ar_err;
      w_ar_ent.id   = bus.memory_arid;
      if (w_ar_err) begin
         w_ar_ent.data = '0;
      end else begin
         w_ar_ent.data = r_mem[w_ar_idx];
      end
   end

   // Latency pipeline: read_latency-1 registers ahead of the FIFO write, which
   // itself is the last stage, so RVALID appears read_latency cycles after AR.
   generate
      if (read_latency > 1) begin : g_pipe
         rd_ent_t r_pipe [0:read_latency-2];

         // Shift read entries toward the response FIFO.
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < read_latency - 1; i++) begin
                  r_pipe[i] <= '0;
               end
            end else begin
               r_pipe[0] <= w_ar_ent;
               for (int i = 1; i < read_latency - 1; i++) begin
                  r_pipe[i] <= r_pipe[i-1];
               end
            end
         end

         assign w_tap = r_pipe[read_latency-2];
      end else begin : g_nopipe
         assign w_tap = w_ar_ent;
      end
   endgenerate

   assign w_push = w_tap.vld;
   assign w_pop  = w_r_hs;
   assign w_head = r_fifo[r_rptr];

   // Outstanding-read and FIFO occupancy bookkeeping.
   always_comb begin
      w_outst_next = r_outst;
      case ({w_ar_hs, w_r_hs})
         2'b10:   w_outst_next = r_outst + ONE_C;
         2'b01:   w_outst_next = r_outst - ONE_C;
         default: w_outst_next = r_outst;
      endcase
      w_fcnt_next = r_fcnt;
      case ({w_push, w_pop})
         2'b10:   w_fcnt_next = r_fcnt + ONE_C;
         2'b01:   w_fcnt_next = r_fcnt - ONE_C;
         default: w_fcnt_next = r_fcnt;
      endcase
   end

   // Read control registers; arready is registered from the next count so it
   // stays low in reset and rises on the first edge after release.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_outst   <= '0;
         r_arready <= 1'b0;
         r_fcnt    <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
      end else begin
         r_outst   <= w_outst_next;
         r_arready <= (w_outst_next < MAXO);
         r_fcnt    <= w_fcnt_next;
         if (w_push) begin
            r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + ONE_P;
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + ONE_P;
         end
      end
   end

   // Response FIFO storage; occupancy is bounded by the outstanding limit.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_fifo[r_wptr] <= w_tap;
      end
   end

   assign bus.memory_arready = r_arready;
   assign bus.memory_rvalid  = w_rvalid;
   assign bus.memory_rlast   = w_rvalid;
   assign bus.memory_rdata   = w_rvalid ? w_head.data : '0;
   assign bus.memory_rid     = w_rvalid ? w_head.id   : 32'd0;
   assign bus.memory_rresp   = (w_rvalid && w_head.err) ? RESP_SLV : RESP_OKAY;

   // ---------------------------------------------------------------- write side
   logic                          r_aw_held;
   logic [memory_addr_width-1:0]  r_aw_addr;
   logic [31:0]                   r_aw_id;
   logic                          r_w_held;
   logic [memory_data_width-1:0]  r_w_data;
   logic [BYTES-1:0]              r_w_strb;
   logic                          r_w_last;
   logic                          r_awready;
   logic                          r_wready;
   logic                          r_bvalid;
   logic [1:0]                    r_bresp;
   logic [31:0]                   r_bid;

   logic                          w_aw_hs;
   logic                          w_w_hs;
   logic                          w_b_hs;
   logic                          w_commit;
   logic                          w_wr_err;
   logic [depth_log2-1:0]         w_wr_idx;
   logic                          w_aw_held_next;
   logic                          w_w_held_next;
   logic                          w_bvalid_next;

   assign w_aw_hs  = bus.memory_awvalid && r_awready;
   assign w_w_hs   = bus.memory_wvalid && r_wready;
   assign w_b_hs   = r_bvalid && bus.memory_bready;
   assign w_commit = r_aw_held && r_w_held;
   assign w_wr_err = addr_err(r_aw_addr) || !r_w_last;
   assign w_wr_idx = addr_index(r_aw_addr);

   // Next state of the holding flags and the B valid.
   always_comb begin
      w_aw_held_next = r_aw_held;
      w_w_held_next  = r_w_held;
      w_bvalid_next  = r_bvalid;
      if (w_commit) begin
         w_aw_held_next = 1'b0;
         w_w_held_next  = 1'b0;
         w_bvalid_next  = 1'b1;
      end else begin
         if (w_aw_hs) begin
            w_aw_held_next = 1'b1;
         end else begin
            w_aw_held_next = r_aw_held;
         end
         if (w_w_hs) begin
            w_w_held_next = 1'b1;
         end else begin
            w_w_held_next = r_w_held;
         end
         if (w_b_hs) begin
            w_bvalid_next = 1'b0;
         end else begin
            w_bvalid_next = r_bvalid;
         end
      end
   end

   // Write channel holding registers and the B response.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_aw_held <= 1'b0;
         r_aw_addr <= '0;
         r_aw_id   <= 32'd0;
         r_w_held  <= 1'b0;
         r_w_data  <= '0;
         r_w_strb  <= '0;
         r_w_last  <= 1'b0;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_bid     <= 32'd0;
      end else begin
         r_aw_held <= w_aw_held_next;
         r_w_held  <= w_w_held_next;
         r_bvalid  <= w_bvalid_next;
         r_awready <= !w_aw_held_next && !w_bvalid_next;
         r_wready  <= !w_w_held_next && !w_bvalid_next;
         if (w_aw_hs) begin
            r_aw_addr <= bus.memory_awaddr;
            r_aw_id   <= bus.memory_awid;
         end
         if (w_w_hs) begin
            r_w_data <= bus.memory_wdata;
            r_w_strb <= bus.memory_wstrb;
            r_w_last <= bus.memory_wlast;
         end
         if (w_commit) begin
            r_bid   <= r_aw_id;
            r_bresp <= w_wr_err ? RESP_SLV : RESP_OKAY;
         end
      end
   end

   // RAM write port; contents survive reset, and the commit is gated by
   // holding flags that reset clears, so no partial write can occur.
   always_ff @(posedge clock) begin
      if (w_commit && !w_wr_err) begin
         r_mem[w_wr_idx] <= strb_merge(r_mem[w_wr_idx], r_w_data, r_w_strb);
      end
   end

   assign bus.memory_awready = r_awready;
   assign bus.memory_wready  = r_wready;
   assign bus.memory_bvalid  = r_bvalid;
   assign bus.memory_bresp   = r_bresp;
   assign bus.memory_bid     = r_bid;

endmodule

// File: tb/tb_axi_point_memory_responder.sv
// Directed bench for axi_point_memory_responder (default parameters:
// 32-bit data, 1024 words at base 0, read latency 2, 4 outstanding reads).
module tb_axi_point_memory_responder;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clock = ~clock;

   axi_point_memory_responder_if #(.memory_addr_width(32), .memory_data_width(32)) bus ();

   axi_point_memory_responder dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [31:0] id;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  resp;
      logic [31:0] data;
   } rvec_t;

   rvec_t tbl [7];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.memory_araddr  = 32'd0;
      bus.memory_arvalid = 1'b0;
      bus.memory_arid    = 32'd0;
      bus.memory_arlen   = 8'd0;
      bus.memory_arsize  = 3'd2;
      bus.memory_rready  = 1'b1;
      bus.memory_awaddr  = 32'd0;
      bus.memory_awid    = 32'd0;
      bus.memory_awvalid = 1'b0;
      bus.memory_wdata   = 32'd0;
      bus.memory_wstrb   = 4'd0;
      bus.memory_wlast   = 1'b0;
      bus.memory_wvalid  = 1'b0;
      bus.memory_bready  = 1'b1;
   endtask

   // Present AW and W together and retire each on its own handshake.
   task automatic wr_issue(input logic [31:0] addr, input logic [31:0] id, input logic [31:0] data,
                           input logic [3:0] strb, input logic last);
      logic a;
      logic w;
      int   cyc;
      bus.memory_awaddr  = addr;
      bus.memory_awid    = id;
      bus.memory_wdata   = data;
      bus.memory_wstrb   = strb;
      bus.memory_wlast   = last;
      bus.memory_awvalid = 1'b1;
      bus.memory_wvalid  = 1'b1;
      cyc = 0;
      while ((bus.memory_awvalid || bus.memory_wvalid) && cyc < 50) begin
         @(negedge clock);
         a = bus.memory_awvalid && bus.memory_awready;
         w = bus.memory_wvalid && bus.memory_wready;
         @(posedge clock); #1;
         if (a) bus.memory_awvalid = 1'b0;
         if (w) bus.memory_wvalid = 1'b0;
         cyc++;
      end
      bus.memory_awvalid = 1'b0;
      bus.memory_wvalid  = 1'b0;
   endtask

   task automatic wait_b(output logic ok, output logic [1:0] bresp, output logic [31:0] bid);
      int cyc;
      cyc = 0;
      do begin
         @(negedge clock);
         cyc++;
      end while (!bus.memory_bvalid && cyc < 50);
      ok    = bus.memory_bvalid;
      bresp = bus.memory_bresp;
      bid   = bus.memory_bid;
      @(posedge clock); #1;
   endtask

   task automatic do_write(input string nm, input logic [31:0] addr, input logic [31:0] id,
                           input logic [31:0] data, input logic [3:0] strb, input logic last,
                           input logic [1:0] exp_resp);
      logic        ok;
      logic [1:0]  br;
      logic [31:0] bi;
      wr_issue(addr, id, data, strb, last);
      wait_b(ok, br, bi);
      chk({nm, "_bvalid"}, 64'(ok), 64'd1);
      chk({nm, "_bresp"}, 64'(br), 64'(exp_resp));
      chk({nm, "_bid"}, 64'(bi), 64'(id));
   endtask

   // Single read with rready held high; lat counts negedges from the AR edge to RVALID.
   task automatic do_read(input logic [31:0] addr, input logic [31:0] id, input logic [7:0] len,
                          input logic [2:0] size, output logic [31:0] rdata, output logic [31:0] rid,
                          output logic [1:0] rresp, output logic rlast, output int lat);
      int   cyc;
      logic hs;
      bus.memory_araddr  = addr;
      bus.memory_arid    = id;
      bus.memory_arlen   = len;
      bus.memory_arsize  = size;
      bus.memory_arvalid = 1'b1;
      cyc = 0;
      hs  = 1'b0;
      while (!hs && cyc < 50) begin
         @(negedge clock);
         hs = bus.memory_arready;
         @(posedge clock); #1;
         cyc++;
      end
      bus.memory_arvalid = 1'b0;
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (!bus.memory_rvalid && lat < 50);
      if (!hs || !bus.memory_rvalid) lat = 99;
      rdata = bus.memory_rdata;
      rid   = bus.memory_rid;
      rresp = bus.memory_rresp;
      rlast = bus.memory_rlast;
      @(posedge clock); #1;
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] ri;
      logic [1:0]  rr;
      logic        rl;
      int          lat;
      logic [31:0] got_id [$];
      logic [1:0]  got_rs [$];
      int          nacc;
      int          bcnt;
      int          stale;
      logic        a;
      logic        hs;
      logic [1:0]  br;
      logic [31:0] bi;
      logic        ok;

      tbl[0] = '{"rd_100",   32'h0000_0100, 32'd7,          8'd0, 3'd2, 2'b00, 32'hDEAD_BEEF};
      tbl[1] = '{"rd_104",   32'h0000_0104, 32'd3,          8'd0, 3'd2, 2'b00, 32'h1234_5678};
      tbl[2] = '{"rd_last",  32'h0000_0FFC, 32'hFFFF_FFFF,  8'd0, 3'd2, 2'b00, 32'hCAFE_F00D};
      tbl[3] = '{"rd_mis",   32'h0000_0102, 32'd1,          8'd0, 3'd2, 2'b10, 32'h0000_0000};
      tbl[4] = '{"rd_range", 32'h0000_1000, 32'd2,          8'd0, 3'd2, 2'b10, 32'h0000_0000};
      tbl[5] = '{"rd_len3",  32'h0000_0100, 32'd4,          8'd3, 3'd2, 2'b10, 32'h0000_0000};
      tbl[6] = '{"rd_size1", 32'h0000_0100, 32'd5,          8'd0, 3'd1, 2'b10, 32'h0000_0000};

      idle_inputs();
      #1;
      chk("rst_arready", 64'(bus.memory_arready), 64'd0);
      chk("rst_awready", 64'(bus.memory_awready), 64'd0);
      chk("rst_wready",  64'(bus.memory_wready),  64'd0);
      chk("rst_rvalid",  64'(bus.memory_rvalid),  64'd0);
      chk("rst_bvalid",  64'(bus.memory_bvalid),  64'd0);
      chk("rst_rdata",   64'(bus.memory_rdata),   64'd0);
      chk("rst_bid",     64'(bus.memory_bid),     64'd0);
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("rel_arready_pre", 64'(bus.memory_arready), 64'd0);
      @(posedge clock); #1;
      chk("rel_arready", 64'(bus.memory_arready), 64'd1);
      chk("rel_awready", 64'(bus.memory_awready), 64'd1);
      chk("rel_wready",  64'(bus.memory_wready),  64'd1);

      // preload, plus writes that must be rejected without touching RAM
      do_write("wr_100", 32'h0000_0100, 32'd11, 32'hDEAD_BEEF, 4'hF, 1'b1, 2'b00);
      do_write("wr_104", 32'h0000_0104, 32'd12, 32'h1234_5678, 4'hF, 1'b1, 2'b00);
      do_write("wr_ffc", 32'h0000_0FFC, 32'd13, 32'hCAFE_F00D, 4'hF, 1'b1, 2'b00);
      do_write("wr_mis", 32'h0000_0106, 32'd14, 32'h0000_0000, 4'hF, 1'b1, 2'b10);
      do_write("wr_nolast", 32'h0000_0104, 32'd15, 32'h0000_0000, 4'hF, 1'b0, 2'b10);

      // table-driven single reads
      for (int i = 0; i < 7; i++) begin
         do_read(tbl[i].addr, tbl[i].id, tbl[i].len, tbl[i].size, rd, ri, rr, rl, lat);
         chk({tbl[i].name, "_lat"},   64'(lat), 64'd2);
         chk({tbl[i].name, "_rid"},   64'(ri),  64'(tbl[i].id));
         chk({tbl[i].name, "_rresp"}, 64'(rr),  64'(tbl[i].resp));
         chk({tbl[i].name, "_rdata"}, 64'(rd),  64'(tbl[i].data));
         chk({tbl[i].name, "_rlast"}, 64'(rl),  64'd1);
      end
      chk("outst_zero_arready", 64'(bus.memory_arready), 64'd1);

      // 8 back-to-back reads against a stalled R channel
      bus.memory_rready  = 1'b0;
      bus.memory_araddr  = 32'h0000_0100;
      bus.memory_arlen   = 8'd0;
      bus.memory_arsize  = 3'd2;
      bus.memory_arid    = 32'd0;
      bus.memory_arvalid = 1'b1;
      nacc = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(negedge clock);
         a = bus.memory_arvalid && bus.memory_arready;
         if (bus.memory_rvalid && bus.memory_rready) begin
            got_id.push_back(bus.memory_rid);
            got_rs.push_back(bus.memory_rresp);
         end
         if (cyc == 8) begin
            chk("bp_accepted", 64'(nacc), 64'd4);
            chk("bp_arready", 64'(bus.memory_arready), 64'd0);
         end
         @(posedge clock); #1;
         if (a) begin
            nacc++;
            if (nacc == 8) bus.memory_arvalid = 1'b0;
            else bus.memory_arid = 32'(nacc);
         end
         if (cyc == 8) bus.memory_rready = 1'b1;
      end
      bus.memory_arvalid = 1'b0;
      chk("bp_count", 64'(got_id.size()), 64'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < got_id.size()) begin
            chk($sformatf("bp_order_%0d", i), 64'(got_id[i]), 64'(i));
            chk($sformatf("bp_resp_%0d", i),  64'(got_rs[i]), 64'd0);
         end
      end
      chk("bp_drained_arready", 64'(bus.memory_arready), 64'd1);

      // W arrives 3 cycles ahead of AW; strobed partial write
      do_write("wr_8_init", 32'h0000_0008, 32'd20, 32'hFFFF_FFFF, 4'hF, 1'b1, 2'b00);
      bus.memory_wdata  = 32'hAAAA_5555;
      bus.memory_wstrb  = 4'b0011;
      bus.memory_wlast  = 1'b1;
      bus.memory_wvalid = 1'b1;
      hs = 1'b0;
      for (int cyc = 0; cyc < 20 && !hs; cyc++) begin
         @(negedge clock);
         hs = bus.memory_wready;
         @(posedge clock); #1;
      end
      bus.memory_wvalid = 1'b0;
      bcnt = 0;
      repeat (3) begin
         @(negedge clock);
         if (bus.memory_bvalid) bcnt++;
         @(posedge clock); #1;
      end
      bus.memory_awaddr  = 32'h0000_0008;
      bus.memory_awid    = 32'h0000_0055;
      bus.memory_awvalid = 1'b1;
      br = 2'b11;
      bi = 32'd0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clock);
         a = bus.memory_awvalid && bus.memory_awready;
         if (bus.memory_bvalid && bus.memory_bready) begin
            bcnt++;
            br = bus.memory_bresp;
            bi = bus.memory_bid;
         end
         @(posedge clock); #1;
         if (a) bus.memory_awvalid = 1'b0;
      end
      bus.memory_awvalid = 1'b0;
      chk("wfirst_bcount", 64'(bcnt), 64'd1);
      chk("wfirst_bresp", 64'(br), 64'd0);
      chk("wfirst_bid", 64'(bi), 64'h55);
      do_read(32'h0000_0008, 32'd21, 8'd0, 3'd2, rd, ri, rr, rl, lat);
      chk("wfirst_readback", 64'(rd), 64'hFFFF_5555);

      // AR handshake on the same edge the write commits: old data returned
      do_write("wr_10_init", 32'h0000_0010, 32'd30, 32'h0000_0000, 4'hF, 1'b1, 2'b00);
      bus.memory_awaddr  = 32'h0000_0010;
      bus.memory_awid    = 32'd31;
      bus.memory_wdata   = 32'h0000_0001;
      bus.memory_wstrb   = 4'hF;
      bus.memory_wlast   = 1'b1;
      bus.memory_awvalid = 1'b1;
      bus.memory_wvalid  = 1'b1;
      @(negedge clock);
      chk("same_aw_ready", 64'({bus.memory_awready, bus.memory_wready}), 64'd3);
      @(posedge clock); #1;
      bus.memory_awvalid = 1'b0;
      bus.memory_wvalid  = 1'b0;
      bus.memory_araddr  = 32'h0000_0010;
      bus.memory_arid    = 32'd9;
      bus.memory_arlen   = 8'd0;
      bus.memory_arsize  = 3'd2;
      bus.memory_arvalid = 1'b1;
      @(negedge clock);
      chk("same_arready", 64'(bus.memory_arready), 64'd1);
      @(posedge clock); #1;
      bus.memory_arvalid = 1'b0;
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (!bus.memory_rvalid && lat < 50);
      chk("same_old_rvalid", 64'(bus.memory_rvalid), 64'd1);
      chk("same_old_data", 64'(bus.memory_rdata), 64'd0);
      @(posedge clock); #1;
      repeat (3) @(posedge clock);
      #1;
      do_read(32'h0000_0010, 32'd10, 8'd0, 3'd2, rd, ri, rr, rl, lat);
      chk("same_new_data", 64'(rd), 64'd1);

      // reset with three reads in flight and a pending B
      bus.memory_rready = 1'b0;
      bus.memory_bready = 1'b0;
      wr_issue(32'h0000_0020, 32'd40, 32'h0000_0077, 4'hF, 1'b1);
      bus.memory_araddr  = 32'h0000_0100;
      bus.memory_arid    = 32'd50;
      bus.memory_arvalid = 1'b1;
      nacc = 0;
      for (int cyc = 0; cyc < 20 && nacc < 3; cyc++) begin
         @(negedge clock);
         a = bus.memory_arready;
         @(posedge clock); #1;
         if (a) begin
            nacc++;
            bus.memory_arid = 32'(50 + nacc);
         end
      end
      bus.memory_arvalid = 1'b0;
      @(negedge clock);
      chk("pre_rst_rvalid", 64'(bus.memory_rvalid), 64'd1);
      chk("pre_rst_bvalid", 64'(bus.memory_bvalid), 64'd1);
      @(posedge clock); #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_valids", 64'({bus.memory_rvalid, bus.memory_bvalid}), 64'd0);
      chk("mid_rst_readies", 64'({bus.memory_arready, bus.memory_awready, bus.memory_wready}), 64'd0);
      chk("mid_rst_rid", 64'(bus.memory_rid), 64'd0);
      idle_inputs();
      bus.memory_rready = 1'b1;
      bus.memory_bready = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("post_rst_readies", 64'({bus.memory_arready, bus.memory_awready, bus.memory_wready}), 64'd7);
      stale = 0;
      repeat (15) begin
         @(negedge clock);
         if (bus.memory_rvalid || bus.memory_bvalid) stale++;
      end
      chk("post_rst_stale", 64'(stale), 64'd0);
      @(posedge clock); #1;
      do_read(32'h0000_0100, 32'd60, 8'd0, 3'd2, rd, ri, rr, rl, lat);
      chk("post_rst_ram_100", 64'(rd), 64'hDEAD_BEEF);
      chk("post_rst_rid", 64'(ri), 64'd60);
      do_read(32'h0000_0020, 32'd61, 8'd0, 3'd2, rd, ri, rr, rl, lat);
      chk("post_rst_ram_20", 64'(rd), 64'h77);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
